i2c_target_responder: RTL and testbench

Synthesizable I2C target (slave) that answers the i2cmb controller on one of its buses. It oversamples SCL/SDA on the system clock, matches a fixed 7-bit address, and backs transfers with an internal auto-incrementing byte register file (EEPROM-style pointer semantics). It is instantiated on a bus of the i2cmb bench as an RTL responder alongside the i2c agent, giving the scoreboard a second, independent far-end model.

---
 rtl/i2c_target_pkg.sv | 30 +++
 rtl/i2c_line_sync.sv | 63 ++++++
 rtl/i2c_target_responder.sv | 195 +++++++++++++++++++
 tb/tb_i2c_target_responder.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_target_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2c_target_pkg
// Description : Shared types and constants for the I2C target responder:
//               FSM state encoding, ACK/NACK bus levels and bit-counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package i2c_target_pkg;

    // State encoding kept as plain sized constants for legacy tool flows.
    typedef logic [2:0] i2c_target_state_t;

    localparam i2c_target_state_t c_st_idle     = 3'd0;
    localparam i2c_target_state_t c_st_addr     = 3'd1;
    localparam i2c_target_state_t c_st_addr_ack = 3'd2;
    localparam i2c_target_state_t c_st_wr_data  = 3'd3;
    localparam i2c_target_state_t c_st_wr_ack   = 3'd4;
    localparam i2c_target_state_t c_st_rd_data  = 3'd5;
    localparam i2c_target_state_t c_st_rd_ack   = 3'd6;
    localparam i2c_target_state_t c_st_wait_evt = 3'd7;

    // Bus level of the 9th bit.
    localparam logic c_ack  = 1'b0;
    localparam logic c_nack = 1'b1;

    // Counts bit positions 0..7 within a byte.
    localparam int c_bit_cnt_w = 4;

endpackage : i2c_target_pkg
`default_nettype wire

// File: rtl/i2c_line_sync.sv
`default_nettype none
// ============================================================================
// Module      : i2c_line_sync
// Description : Synchronises the resolved SCL/SDA bus wires into the system
//               clock domain and derives single-cycle line events.
//   clk_i        system clock
//   rst_n_i      asynchronous active-low reset (synchronisers reset to 1)
//   scl_i/sda_i  raw bus wires
//   sda_o        synchronised SDA level (bit value at SCL rise)
//   scl_rise_o   SCL 0->1 pulse
//   scl_fall_o   SCL 1->0 pulse
//   start_o      SDA 1->0 while SCL high
//   stop_o       SDA 0->1 while SCL high
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_d;
    logic                   r_sda_d;
    logic                   w_scl;
    logic                   w_sda;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_i};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_i};
            r_scl_d    <= w_scl;
            r_sda_d    <= w_sda;
        end
    end

    assign w_scl = r_scl_sync[SYNC_STAGES-1];
    assign w_sda = r_sda_sync[SYNC_STAGES-1];

    assign sda_o      = w_sda;
    assign scl_rise_o = w_scl & ~r_scl_d;
    assign scl_fall_o = ~w_scl & r_scl_d;
    // SCL must be high on both samples so that an SDA change racing an SCL
    // edge is never mistaken for a START/STOP.
    assign start_o    = w_scl & r_scl_d & r_sda_d & ~w_sda;
    assign stop_o     = w_scl & r_scl_d & ~r_sda_d & w_sda;

endmodule : i2c_line_sync
`default_nettype wire

// File: rtl/i2c_target_responder.sv
`default_nettype none
// ============================================================================
// Module      : i2c_target_responder
// Description : I2C target with a fixed 7-bit address backed by an
//               auto-incrementing byte register file (EEPROM-style pointer:
//               first write byte loads the pointer, later bytes are stored).
//   clk_i/rst_n_i   system clock, asynchronous active-low reset
//   scl_i/sda_i     resolved bus wires
//   sda_oe_o        1 = pull SDA low
//   busy_o          addressed and transaction in progress
//   wr_strobe_o     one-cycle pulse per stored byte, with wr_addr_o/wr_data_o
//   start_det_o     one-cycle pulse per START / repeated START
//   stop_det_o      one-cycle pulse per STOP
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_target_responder
    import i2c_target_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR = 7'h22,
    parameter int         DEPTH       = 16,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     scl_i,
    input  logic                     sda_i,
    output logic                     sda_oe_o,
    output logic                     busy_o,
    output logic                     wr_strobe_o,
    output logic [$clog2(DEPTH)-1:0] wr_addr_o,
    output logic [7:0]               wr_data_o,
    output logic                     start_det_o,
    output logic                     stop_det_o
);

    localparam int                 c_ptr_w   = $clog2(DEPTH);
    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);

    logic w_sda;
    logic w_scl_rise;
    logic w_scl_fall;
    logic w_start;
    logic w_stop;

    i2c_line_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_line_sync (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .scl_i      (scl_i),
        .sda_i      (sda_i),
        .sda_o      (w_sda),
        .scl_rise_o (w_scl_rise),
        .scl_fall_o (w_scl_fall),
        .start_o    (w_start),
        .stop_o     (w_stop)
    );

    i2c_target_state_t        r_state;
    logic [c_bit_cnt_w-1:0]   r_bit_cnt;
    logic [6:0]               r_shift;
    logic                     r_rw;
    logic                     r_first;
    logic [c_ptr_w-1:0]       r_ptr;
    logic [7:0]               r_mem [DEPTH];

    logic [7:0]               w_byte;
    logic                     w_last_bit;
    logic [7:0]               w_rd_byte;
    logic [2:0]               w_rd_idx;

    // Byte as it stands once the current SCL-rise bit is shifted in.
    assign w_byte     = {r_shift, w_sda};
    assign w_last_bit = (r_bit_cnt == c_bit_cnt_w'(7));
    assign w_rd_byte  = r_mem[r_ptr];
    assign w_rd_idx   = 3'd7 - r_bit_cnt[2:0];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= c_st_idle;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_rw        <= 1'b0;
            r_first     <= 1'b0;
            r_ptr       <= '0;
            sda_oe_o    <= 1'b0;
            busy_o      <= 1'b0;
            wr_strobe_o <= 1'b0;
            wr_addr_o   <= '0;
            wr_data_o   <= '0;
            start_det_o <= 1'b0;
            stop_det_o  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            start_det_o <= w_start;
            stop_det_o  <= w_stop;
            wr_strobe_o <= 1'b0;

            if (w_stop) begin
                // Partial byte is dropped: no store, pointer untouched.
                r_state   <= c_st_idle;
                r_bit_cnt <= '0;
                sda_oe_o  <= 1'b0;
                busy_o    <= 1'b0;
            end else if (w_start) begin
                r_state   <= c_st_addr;
                r_bit_cnt <= '0;
                sda_oe_o  <= 1'b0;
                busy_o    <= 1'b0;
            end else if (w_scl_rise) begin
                case (r_state)
                    c_st_addr: begin
                        r_shift <= w_byte[6:0];
                        if (w_last_bit) begin
                            r_bit_cnt <= '0;
                            if (w_byte[7:1] == TARGET_ADDR) begin
                                r_state <= c_st_addr_ack;
                                r_rw    <= w_byte[0];
                                busy_o  <= 1'b1;
                            end else begin
                                r_state <= c_st_wait_evt;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                    c_st_addr_ack: begin
                        r_bit_cnt <= '0;
                        if (r_rw) begin
                            r_state <= c_st_rd_data;
                        end else begin
                            r_state <= c_st_wr_data;
                            r_first <= 1'b1;
                        end
                    end
                    c_st_wr_data: begin
                        r_shift <= w_byte[6:0];
                        if (w_last_bit) begin
                            r_bit_cnt <= '0;
                            r_state   <= c_st_wr_ack;
                            if (r_first) begin
                                r_ptr   <= w_byte[c_ptr_w-1:0];
                                r_first <= 1'b0;
                            end else begin
                                r_mem[r_ptr] <= w_byte;
                                wr_strobe_o  <= 1'b1;
                                wr_addr_o    <= r_ptr;
                                wr_data_o    <= w_byte;
                                r_ptr        <= r_ptr + c_ptr_one;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                    c_st_wr_ack: begin
                        r_state <= c_st_wr_data;
                    end
                    c_st_rd_data: begin
                        if (w_last_bit) begin
                            r_bit_cnt <= '0;
                            r_state   <= c_st_rd_ack;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                    c_st_rd_ack: begin
                        // The byte was delivered whatever the answer.
                        r_ptr <= r_ptr + c_ptr_one;
                        if (w_sda == c_ack) begin
                            r_state <= c_st_rd_data;
                        end else begin
                            r_state <= c_st_wait_evt;
                            busy_o  <= 1'b0;
                        end
                    end
                    default: begin
                    end
                endcase
            end else if (w_scl_fall) begin
                case (r_state)
                    c_st_addr_ack,
                    c_st_wr_ack:  sda_oe_o <= 1'b1;
                    // The fall that ends an ACK phase directly presents the
                    // next read bit, so the ACK drive may simply continue.
                    c_st_rd_data: sda_oe_o <= ~w_rd_byte[w_rd_idx];
                    default:      sda_oe_o <= 1'b0;
                endcase
            end
        end
    end

endmodule : i2c_target_responder
`default_nettype wire

// File: tb/tb_i2c_target_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_target_responder
// Description : Directed bench. A transaction-level model (byte array plus
//               pointer) predicts ACKs, read bytes and write strobes; a
//               per-cycle monitor checks strobes, SDA drive timing and
//               START/STOP pulse counts against it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_target_responder;

    localparam int Q = 6;   // clocks per quarter SCL period

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       scl      = 1'b1;
    logic       sda_ctrl = 1'b1;
    logic       sda_oe_o;
    logic       busy_o;
    logic       wr_strobe_o;
    logic [3:0] wr_addr_o;
    logic [7:0] wr_data_o;
    logic       start_det_o;
    logic       stop_det_o;
    wire        sda_line = sda_ctrl & ~sda_oe_o;

    i2c_target_responder #(
        .TARGET_ADDR (7'h22),
        .DEPTH       (16),
        .SYNC_STAGES (2)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .scl_i       (scl),
        .sda_i       (sda_line),
        .sda_oe_o    (sda_oe_o),
        .busy_o      (busy_o),
        .wr_strobe_o (wr_strobe_o),
        .wr_addr_o   (wr_addr_o),
        .wr_data_o   (wr_data_o),
        .start_det_o (start_det_o),
        .stop_det_o  (stop_det_o)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model state
    logic [7:0]  m_mem [16];
    int          m_ptr   = 0;
    bit          m_first = 0;
    logic [11:0] exp_wr [$];
    int          m_starts = 0, m_stops = 0;
    int          dut_starts = 0, dut_stops = 0;
    bit          quiet = 0;
    logic        prev_oe = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (start_det_o) dut_starts++;
            if (stop_det_o)  dut_stops++;
            if (wr_strobe_o) begin
                if (exp_wr.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_strobe: got addr %0d data 0x%0h expected none", wr_addr_o, wr_data_o);
                end else begin
                    chk("wr_strobe", {wr_addr_o, wr_data_o}, exp_wr.pop_front());
                end
            end
            if (sda_oe_o !== prev_oe) chk("oe_change_scl_low", scl, 0);
            if (quiet) begin
                chk("quiet_oe", sda_oe_o, 0);
                chk("quiet_busy", busy_o, 0);
            end
        end
        prev_oe = sda_oe_o;
    end

    // Bus-level controller tasks (each bit starts and ends with SCL low)
    task automatic start_cond();
        if (scl == 1'b0) begin
            wait_clk(Q); sda_ctrl = 1'b1;
            wait_clk(Q); scl = 1'b1;
            wait_clk(Q);
        end
        sda_ctrl = 1'b0;
        wait_clk(Q); scl = 1'b0;
        m_starts++;
    endtask

    task automatic bus_stop();
        wait_clk(Q); sda_ctrl = 1'b0;
        wait_clk(Q); scl = 1'b1;
        wait_clk(Q); sda_ctrl = 1'b1;
        wait_clk(2*Q);
    endtask

    task automatic stop_cond();
        bus_stop();
        m_stops++;
    endtask

    task automatic send_bit(input logic b);
        wait_clk(Q); sda_ctrl = b;
        wait_clk(Q); scl = 1'b1;
        wait_clk(2*Q); scl = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output bit acked);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        wait_clk(Q); sda_ctrl = 1'b1;
        wait_clk(Q); scl = 1'b1;
        wait_clk(Q); acked = (sda_line == 1'b0);
        wait_clk(Q); scl = 1'b0;
    endtask

    task automatic read_byte(output logic [7:0] b, input bit nack);
        for (int i = 7; i >= 0; i--) begin
            wait_clk(Q); sda_ctrl = 1'b1;
            wait_clk(Q); scl = 1'b1;
            wait_clk(Q); b[i] = sda_line;
            wait_clk(Q); scl = 1'b0;
        end
        wait_clk(Q); sda_ctrl = nack;
        wait_clk(Q); scl = 1'b1;
        wait_clk(2*Q); scl = 1'b0;
    endtask

    // Transaction-level model wrappers
    task automatic addr_phase(input logic [6:0] a, input bit rw);
        bit ack;
        send_byte({a, rw}, ack);
        chk("addr_ack", ack, (a == 7'h22));
        if (a == 7'h22 && !rw) m_first = 1;
    endtask

    task automatic write_data(input logic [7:0] d);
        bit          ack;
        logic [3:0]  p;
        if (m_first) begin
            m_first = 0;
            m_ptr   = d % 16;
        end else begin
            p = 4'(m_ptr);
            exp_wr.push_back({p, d});
            m_mem[m_ptr] = d;
            m_ptr = (m_ptr + 1) % 16;
        end
        send_byte(d, ack);
        chk("data_ack", ack, 1);
    endtask

    task automatic read_data(input bit nack, output logic [7:0] got);
        read_byte(got, nack);
        chk("rd_data_model", got, m_mem[m_ptr]);
        m_ptr = (m_ptr + 1) % 16;
    endtask

    task automatic check_events();
        wait_clk(4);
        chk("start_count", dut_starts, m_starts);
        chk("stop_count", dut_stops, m_stops);
        chk("strobes_pending", exp_wr.size(), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] got;
        for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;

        // Reset state
        wait_clk(5);
        chk("rst_sda_oe", sda_oe_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_wr_strobe", wr_strobe_o, 0);
        chk("rst_wr_addr", wr_addr_o, 0);
        chk("rst_wr_data", wr_data_o, 0);
        chk("rst_start_det", start_det_o, 0);
        chk("rst_stop_det", stop_det_o, 0);
        rst_n = 1'b1;
        wait_clk(5);

        // T1: write pointer 5, then 0xA1, 0xB2
        start_cond();
        addr_phase(7'h22, 0);
        write_data(8'h05);
        write_data(8'hA1);
        write_data(8'hB2);
        stop_cond();
        check_events();

        // T2: set pointer, repeated START, read ACK then NACK
        start_cond();
        addr_phase(7'h22, 0);
        write_data(8'h05);
        start_cond();
        addr_phase(7'h22, 1);
        read_data(0, got);
        chk("t2_byte0", got, 8'hA1);
        chk("t2_busy_mid", busy_o, 1);
        read_data(1, got);
        chk("t2_byte1", got, 8'hB2);
        wait_clk(4);
        chk("t2_busy_after_nack", busy_o, 0);
        stop_cond();
        check_events();

        // T3: foreign address, never driven, never busy
        quiet = 1;
        start_cond();
        addr_phase(7'h23, 0);
        stop_cond();
        quiet = 0;
        check_events();

        // T4: pointer wrap
        start_cond();
        addr_phase(7'h22, 0);
        write_data(8'h0F);
        write_data(8'h11);
        write_data(8'h22);
        stop_cond();
        start_cond();
        addr_phase(7'h22, 0);
        write_data(8'h0F);
        start_cond();
        addr_phase(7'h22, 1);
        read_data(0, got);
        chk("t4_byte15", got, 8'h11);
        read_data(1, got);
        chk("t4_byte0_wrap", got, 8'h22);
        stop_cond();
        check_events();

        // T5: STOP after 4 bits of a data byte
        start_cond();
        addr_phase(7'h22, 0);
        write_data(8'h05);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        stop_cond();
        start_cond();
        addr_phase(7'h22, 1);
        read_data(1, got);
        chk("t5_unchanged", got, 8'hA1);
        stop_cond();
        check_events();

        // T6: async reset while driving a 0 read bit (mem[0] = 0x22, MSB 0)
        start_cond();
        addr_phase(7'h22, 0);
        write_data(8'h00);
        start_cond();
        addr_phase(7'h22, 1);
        wait_clk(Q);
        chk("t6_oe_driving", sda_oe_o, 1);
        #2 rst_n = 1'b0;
        #1 chk("t6_oe_async_release", sda_oe_o, 0);
        for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
        m_ptr   = 0;
        m_first = 0;
        bus_stop();
        wait_clk(2);
        dut_starts = 0; dut_stops = 0;
        m_starts   = 0; m_stops   = 0;
        rst_n = 1'b1;
        wait_clk(4);
        start_cond();
        addr_phase(7'h22, 1);
        read_data(1, got);
        chk("t6_mem0_cleared", got, 8'h00);
        stop_cond();
        start_cond();
        addr_phase(7'h22, 0);
        write_data(8'h05);
        start_cond();
        addr_phase(7'h22, 1);
        read_data(1, got);
        chk("t6_mem5_cleared", got, 8'h00);
        stop_cond();
        check_events();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_i2c_target_responder
`default_nettype wire
